// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone master bridge.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'd0,
        WB_BUSY       = 2'd1,
        WB_WAIT_STALL = 2'd2
    } wb_state_e;

    // Stall vector index of the stage that consumes the returned data.
    localparam int STALL_IF  = 1;
    localparam int STALL_MEM = 4;

endpackage

// File: rtl/wb_bus_if.sv
// Wishbone B3 classic master bridge for an openmips memory port, with read buffer and ack timeout.
// Latency: request at cycle N gives cyc at N+1; the CPU is held via o_stallreq until ack/timeout/flush.
module wb_bus_if
    import wb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int STALL_BIT = STALL_MEM,
    parameter int TIMEOUT   = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [5:0]        i_stall,
    input  logic              i_flush,
    input  logic              i_cpu_ce,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_data,
    input  logic [3:0]        i_cpu_sel,
    output logic [DATA_W-1:0] o_cpu_data,
    output logic              o_stallreq,
    output logic              o_bus_err,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_wb_ack,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [3:0]        o_wb_sel,
    output logic              o_wb_we,
    output logic              o_wb_stb,
    output logic              o_wb_cyc
);

    localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    wb_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [3:0]        wb_sel_q;
    logic              wb_we_q;
    logic              wb_cyc_q;
    logic [DATA_W-1:0] rd_buf_q;
    logic              bus_err_q;

    logic stall_bit;
    logic timeout_hit;
    logic unused_stall;

    assign stall_bit    = i_stall[STALL_BIT];
    assign unused_stall = ^i_stall;

    // Last waited cycle with no ack and no flush: terminate the cycle as if acked with zero data.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == WB_BUSY) && !i_flush && !i_wb_ack
                         && (cnt_q == CNT_W'(TO_LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= WB_IDLE;
            cnt_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_cyc_q  <= 1'b0;
            rd_buf_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (i_cpu_ce && !i_flush) begin
                        wb_addr_q <= i_cpu_addr;
                        wb_data_q <= i_cpu_data;
                        wb_sel_q  <= i_cpu_sel;
                        wb_we_q   <= i_cpu_we;
                        wb_cyc_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    if (i_flush || i_wb_ack || timeout_hit) begin
                        wb_addr_q <= '0;
                        wb_data_q <= '0;
                        wb_sel_q  <= '0;
                        wb_we_q   <= 1'b0;
                        wb_cyc_q  <= 1'b0;
                    end
                    if (i_flush) begin
                        rd_buf_q <= '0;
                        state_q  <= WB_IDLE;
                    end else if (i_wb_ack || timeout_hit) begin
                        rd_buf_q  <= i_wb_ack ? i_wb_data : '0;
                        bus_err_q <= timeout_hit;
                        state_q   <= stall_bit ? WB_WAIT_STALL : WB_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WB_WAIT_STALL: begin
                    if (i_flush) begin
                        rd_buf_q <= '0;
                        state_q  <= WB_IDLE;
                    end else if (!stall_bit) begin
                        state_q <= WB_IDLE;
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    always_comb begin
        o_stallreq = 1'b0;
        o_cpu_data = '0;
        case (state_q)
            WB_IDLE: o_stallreq = i_cpu_ce & ~i_flush;
            WB_BUSY: begin
                if (!i_flush) begin
                    if (i_wb_ack) begin
                        o_cpu_data = i_wb_data;
                    end else if (!timeout_hit) begin
                        o_stallreq = 1'b1;
                    end
                end
            end
            WB_WAIT_STALL: o_cpu_data = rd_buf_q;
            default: begin
                o_stallreq = 1'b0;
                o_cpu_data = '0;
            end
        endcase
    end

    // stb and cyc share one register so stb can never appear without cyc.
    assign o_wb_addr = wb_addr_q;
    assign o_wb_data = wb_data_q;
    assign o_wb_sel  = wb_sel_q;
    assign o_wb_we   = wb_we_q;
    assign o_wb_stb  = wb_cyc_q;
    assign o_wb_cyc  = wb_cyc_q;
    assign o_bus_err = bus_err_q;

endmodule
